neuron_sequencer: RTL and testbench

NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

---
 rtl/neuron_sequencer.sv | 149 ++++++++++++++
 tb/tb_neuron_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_sequencer.sv
// rtl/neuron_sequencer.sv - per-image neuron scoring sequencer with running argmax
`timescale 1ns/1ps
module neuron_sequencer #(
  parameter int NEURONS      = 10,
  parameter int PIXEL_N      = 785,
  parameter int PARALLEL     = 4,
  parameter int BUS_WIDTH    = 7,
  parameter int VAL_SIZE     = 26,
  parameter int DRAIN_CYCLES = 12,
  localparam int CHUNKS      = (PIXEL_N + PARALLEL*BUS_WIDTH - 1) / (PARALLEL*BUS_WIDTH),
  localparam int NW          = $clog2(NEURONS),
  localparam int CW          = $clog2(CHUNKS + 1)
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic                start,
  input  logic [VAL_SIZE-1:0] dp_value,
  output logic                dp_clear,
  output logic                fetch_en,
  output logic [NW-1:0]       neuron_idx,
  output logic [CW-1:0]       chunk_idx,
  output logic                busy,
  output logic                done,
  output logic [NW-1:0]       class_idx,
  output logic [VAL_SIZE-1:0] max_value
);

  localparam int PW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [NW-1:0]       neuron_q, neuron_d;
  logic [CW-1:0]       chunk_q, chunk_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [NW-1:0]       class_q, class_d;
  logic [VAL_SIZE-1:0] max_q, max_d;
  logic                dp_clear_q, dp_clear_d;
  logic                fetch_en_q, fetch_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d  = state_q;
    neuron_d = neuron_q;
    chunk_d  = chunk_q;
    phase_d  = phase_q;
    drain_d  = drain_q;
    class_d  = class_q;
    max_d    = max_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = CLEAR;
          neuron_d = '0;
        end
      end
      CLEAR: begin
        state_d = FEED;
        chunk_d = '0;
        phase_d = '0;
      end
      FEED: begin
        if (phase_q == PW'(BUS_WIDTH - 1)) begin
          phase_d = '0;
          chunk_d = chunk_q + 1'b1;
          if (chunk_q == CW'(CHUNKS - 1)) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) state_d = CAPTURE;
        else drain_d = drain_q + 1'b1;
      end
      CAPTURE: begin
        // Strict compare keeps the earlier (lower) neuron on ties.
        if (neuron_q == '0 || $signed(dp_value) > $signed(max_q)) begin
          max_d   = dp_value;
          class_d = neuron_q;
        end
        if (neuron_q == NW'(NEURONS - 1)) begin
          state_d = DONE;
        end else begin
          neuron_d = neuron_q + 1'b1;
          state_d  = CLEAR;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    dp_clear_d = (state_d == CLEAR);
    fetch_en_d = (state_d == FEED);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q    <= IDLE;
      neuron_q   <= '0;
      chunk_q    <= '0;
      phase_q    <= '0;
      drain_q    <= '0;
      class_q    <= '0;
      max_q      <= '0;
      dp_clear_q <= 1'b0;
      fetch_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      neuron_q   <= neuron_d;
      chunk_q    <= chunk_d;
      phase_q    <= phase_d;
      drain_q    <= drain_d;
      class_q    <= class_d;
      max_q      <= max_d;
      dp_clear_q <= dp_clear_d;
      fetch_en_q <= fetch_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign dp_clear   = dp_clear_q;
  assign fetch_en   = fetch_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign neuron_idx = neuron_q;
  assign chunk_idx  = chunk_q;
  assign class_idx  = class_q;
  assign max_value  = max_q;

endmodule

// File: tb/tb_neuron_sequencer.sv
// tb/tb_neuron_sequencer.sv - directed and randomized checks of neuron_sequencer
`timescale 1ns/1ps
module tb_neuron_sequencer;

  localparam int NEURONS = 10;
  localparam int VS      = 26;
  localparam int LAT     = 2171;
  localparam int FEED_N  = 203;
  localparam int NCHUNK  = 29;

  logic          clk = 1'b0;
  logic          GlobalReset;
  logic          start;
  logic [VS-1:0] dp_value;
  logic          dp_clear, fetch_en, busy, done;
  logic [3:0]    neuron_idx, class_idx;
  logic [4:0]    chunk_idx;
  logic [VS-1:0] max_value;

  logic [VS-1:0] scores [NEURONS];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dp_value = (neuron_idx < 4'(NEURONS)) ? scores[neuron_idx] : '0;

  neuron_sequencer dut (
    .clk(clk), .GlobalReset(GlobalReset), .start(start), .dp_value(dp_value),
    .dp_clear(dp_clear), .fetch_en(fetch_en), .neuron_idx(neuron_idx),
    .chunk_idx(chunk_idx), .busy(busy), .done(done),
    .class_idx(class_idx), .max_value(max_value)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dp_clear"}, longint'(dp_clear), 0);
    chk({tag, "_fetch_en"}, longint'(fetch_en), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_neuron_idx"}, longint'(neuron_idx), 0);
    chk({tag, "_chunk_idx"}, longint'(chunk_idx), 0);
    chk({tag, "_class_idx"}, longint'(class_idx), 0);
    chk({tag, "_max_value"}, longint'(max_value), 0);
  endtask

  // One image: first-highest argmax from the score table, plus trace properties.
  task automatic do_run(input string tag, input int repulse_at, input bit hold_start);
    int exp_cls = 0;
    longint exp_max;
    int cyc = 0, done_cyc = -1, clears = 0, runs = 0, run_len = 0, feed_pos = 0;
    int bad_run = 0, bad_chunk = 0, bad_busy = 0, extra_done = 0;
    exp_max = longint'($signed(scores[0]));
    for (int i = 1; i < NEURONS; i++)
      if (longint'($signed(scores[i])) > exp_max) begin
        exp_max = longint'($signed(scores[i]));
        exp_cls = i;
      end

    @(negedge clk);
    start = 1'b1;
    while (cyc < LAT + 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (dp_clear) begin
        clears++;
        feed_pos = 0;
      end
      if (fetch_en) begin
        if (chunk_idx !== 5'(feed_pos / 7)) bad_chunk++;
        feed_pos++;
        run_len++;
      end else if (run_len != 0) begin
        if (run_len != FEED_N || chunk_idx !== 5'(NCHUNK)) bad_run++;
        runs++;
        run_len = 0;
      end
      if (!busy && !done) bad_busy++;
      if (!hold_start && cyc == 1) start = 1'b0;
      if (cyc == repulse_at) start = 1'b1;
      if (cyc == repulse_at + 1) start = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    chk({tag, "_latency"}, done_cyc, LAT);
    chk({tag, "_dp_clear_pulses"}, clears, NEURONS);
    chk({tag, "_feed_runs"}, runs, NEURONS);
    chk({tag, "_feed_run_shape"}, bad_run, 0);
    chk({tag, "_chunk_sequence"}, bad_chunk, 0);
    chk({tag, "_busy_during_run"}, bad_busy, 0);
    chk({tag, "_class_idx"}, longint'(class_idx), exp_cls);
    chk({tag, "_max_value"}, longint'($signed(max_value)), exp_max);

    @(posedge clk);
    #1;
    chk({tag, "_idle_after_done_busy"}, longint'(busy), 0);
    chk({tag, "_idle_after_done_done"}, longint'(done), 0);
    if (!hold_start) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        if (done || busy) extra_done++;
      end
      chk({tag, "_no_second_run"}, extra_done, 0);
    end
  endtask

  initial begin
    GlobalReset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < NEURONS; i++) scores[i] = '0;
    #1;
    chk_all_zero("reset_async");
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    @(negedge clk);
    GlobalReset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_idle_busy", longint'(busy), 0);

    for (int i = 0; i < NEURONS; i++) scores[i] = VS'(i * 100);
    do_run("linear", -1, 1'b0);
    chk("linear_class_const", longint'(class_idx), 9);
    chk("linear_max_const", longint'($signed(max_value)), 900);

    scores[0] = VS'(5);   scores[1] = VS'(-3); scores[2] = VS'(40); scores[3] = VS'(40);
    scores[4] = VS'(7);   scores[5] = VS'(1);  scores[6] = VS'(2);  scores[7] = VS'(3);
    scores[8] = VS'(4);   scores[9] = VS'(0);
    do_run("tie", -1, 1'b0);
    chk("tie_class_const", longint'(class_idx), 2);

    scores[0] = VS'(-50); scores[1] = VS'(-20); scores[2] = VS'(-7);  scores[3] = VS'(-100);
    scores[4] = VS'(-3);  scores[5] = VS'(-9);  scores[6] = VS'(-1);  scores[7] = VS'(-2);
    scores[8] = VS'(-1000); scores[9] = VS'(-5);
    do_run("negative", -1, 1'b0);
    chk("negative_class_const", longint'(class_idx), 6);
    chk("negative_max_const", longint'($signed(max_value)), -1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NEURONS; i++) begin
        scores[i] = VS'($urandom);
        if (i > 0 && $urandom_range(2) == 0) scores[i] = scores[$urandom_range(i - 1)];
      end
      do_run($sformatf("random%0d", r), (r == 1) ? 500 : -1, 1'b0);
    end

    for (int i = 0; i < NEURONS; i++) scores[i] = VS'($urandom);
    do_run("hold_start", -1, 1'b1);
    @(posedge clk);
    #1;
    chk("hold_start_restart_busy", longint'(busy), 1);
    start = 1'b0;

    repeat (997) @(posedge clk);
    #2;
    GlobalReset = 1'b1;
    #1;
    chk_all_zero("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("midrun_reset_held");
    @(negedge clk);
    GlobalReset = 1'b0;
    @(posedge clk);
    #1;
    chk("after_abort_busy", longint'(busy), 0);
    for (int i = 0; i < NEURONS; i++) scores[i] = VS'($urandom);
    do_run("after_reset", -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
